// File: rtl/io_bridge.sv
// rtl/io_bridge.sv - miniRV data-side bridge: DRAM / LED / switch / button / 7-seg routing
module io_bridge #(
    parameter int SCAN_DIV = 20000,
    parameter int DRAM_AW  = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        cpu_adr,
    input  logic [31:0]        cpu_wdin,
    input  logic               cpu_we,
    output logic [31:0]        cpu_rd,
    output logic [DRAM_AW-1:0] dram_addr,
    output logic [31:0]        dram_wdin,
    output logic               dram_we,
    input  logic [31:0]        dram_rd,
    input  logic [23:0]        sw,
    input  logic [4:0]         btn,
    output logic [23:0]        led,
    output logic [7:0]         dig_en,
    output logic [7:0]         seg
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    localparam logic [31:0] ADR_DISP = 32'hFFFF_F000;
    localparam logic [31:0] ADR_LED  = 32'hFFFF_F060;
    localparam logic [31:0] ADR_SW   = 32'hFFFF_F070;
    localparam logic [31:0] ADR_BTN  = 32'hFFFF_F078;

    logic            w_is_dram;
    logic            w_sel_disp;
    logic            w_sel_led;
    logic            w_sel_sw;
    logic            w_sel_btn;
    logic [3:0]      w_nib;
    logic [7:0]      w_dig_next;
    logic [7:0]      w_seg_next;

    logic [31:0]     r_disp;
    logic [23:0]     r_led;
    logic [23:0]     r_sw_m;
    logic [23:0]     r_sw_s;
    logic [4:0]      r_btn_m;
    logic [4:0]      r_btn_s;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_dig_en;
    logic [7:0]      r_seg;

    // Active-low {g,f,e,d,c,b,a} glyphs for one hex nibble.
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    // Anything outside the top 4 KiB page goes to DRAM; peripherals need an exact match.
    assign w_is_dram  = (cpu_adr[31:12] != 20'hFFFFF);
    assign w_sel_disp = (cpu_adr == ADR_DISP);
    assign w_sel_led  = (cpu_adr == ADR_LED);
    assign w_sel_sw   = (cpu_adr == ADR_SW);
    assign w_sel_btn  = (cpu_adr == ADR_BTN);

    assign dram_addr = cpu_adr[DRAM_AW+1:2];
    assign dram_wdin = cpu_wdin;
    assign dram_we   = cpu_we & w_is_dram;

    assign w_nib      = r_disp[{r_idx, 2'b00} +: 4];
    assign w_dig_next = ~(8'h01 << r_idx);
    assign w_seg_next = {1'b1, hex7(w_nib)};

    assign led    = r_led;
    assign dig_en = r_dig_en;
    assign seg    = r_seg;

    // Load data mux; write-only and unmapped locations read as zero.
    always_comb begin
        cpu_rd = 32'h0;
        if (w_is_dram) begin
            cpu_rd = dram_rd;
        end else if (w_sel_sw) begin
            cpu_rd = {8'h0, r_sw_s};
        end else if (w_sel_btn) begin
            cpu_rd = {27'h0, r_btn_s};
        end
    end

    // Peripheral store registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_disp <= 32'h0;
            r_led  <= 24'h0;
        end else if (cpu_we) begin
            if (w_sel_disp) r_disp <= cpu_wdin;
            if (w_sel_led)  r_led  <= cpu_wdin[23:0];
        end
    end

    // Two-flop synchronisers for the asynchronous board inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sw_m  <= 24'h0;
            r_sw_s  <= 24'h0;
            r_btn_m <= 5'h0;
            r_btn_s <= 5'h0;
        end else begin
            r_sw_m  <= sw;
            r_sw_s  <= r_sw_m;
            r_btn_m <= btn;
            r_btn_s <= r_btn_m;
        end
    end

    // Scan timer: each digit is held for SCAN_DIV cycles, digit index wraps 7->0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= 3'd0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_idx <= r_idx + 3'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Registered display pins, one cycle behind the index and display value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dig_en <= 8'hFE;
            r_seg    <= 8'hC0;
        end else begin
            r_dig_en <= w_dig_next;
            r_seg    <= w_seg_next;
        end
    end

endmodule

// File: tb/tb_io_bridge.sv
// tb/tb_io_bridge.sv - randomized self-checking bench for io_bridge with reference model
module tb_io_bridge;

    localparam int SCAN_DIV = 4;
    localparam int DRAM_AW  = 14;

    logic               clk;
    logic               rst_n;
    logic [31:0]        cpu_adr;
    logic [31:0]        cpu_wdin;
    logic               cpu_we;
    logic [31:0]        cpu_rd;
    logic [DRAM_AW-1:0] dram_addr;
    logic [31:0]        dram_wdin;
    logic               dram_we;
    logic [31:0]        dram_rd;
    logic [23:0]        sw;
    logic [4:0]         btn;
    logic [23:0]        led;
    logic [7:0]         dig_en;
    logic [7:0]         seg;

    io_bridge #(.SCAN_DIV(SCAN_DIV), .DRAM_AW(DRAM_AW)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_adr(cpu_adr), .cpu_wdin(cpu_wdin),
        .cpu_we(cpu_we), .cpu_rd(cpu_rd), .dram_addr(dram_addr),
        .dram_wdin(dram_wdin), .dram_we(dram_we), .dram_rd(dram_rd),
        .sw(sw), .btn(btn), .led(led), .dig_en(dig_en), .seg(seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int unsigned m_cyc;
    logic [31:0] m_disp;
    logic [23:0] m_led;
    logic [7:0]  m_dig;
    logic [7:0]  m_seg;
    logic [23:0] m_sw_hist [2];
    logic [4:0]  m_btn_hist [2];

    function automatic logic [7:0] glyph(input logic [3:0] v);
        logic [7:0] tab [16];
        tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        return tab[v];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_cyc = 0;
        m_disp = 32'h0;
        m_led = 24'h0;
        m_dig = 8'hFE;
        m_seg = 8'hC0;
        m_sw_hist = '{24'h0, 24'h0};
        m_btn_hist = '{5'h0, 5'h0};
    endtask

    // One clock edge: advance the model with the pre-edge state, then sample 1 ns later.
    task automatic tick();
        int idx;
        @(posedge clk);
        idx = int'((m_cyc / SCAN_DIV) % 8);
        m_dig = ~(8'h01 << idx);
        m_seg = glyph(m_disp[4*idx +: 4]);
        if (cpu_we && cpu_adr == 32'hFFFF_F000) m_disp = cpu_wdin;
        if (cpu_we && cpu_adr == 32'hFFFF_F060) m_led = cpu_wdin[23:0];
        m_sw_hist[1] = m_sw_hist[0];
        m_sw_hist[0] = sw;
        m_btn_hist[1] = m_btn_hist[0];
        m_btn_hist[0] = btn;
        m_cyc++;
        #1;
    endtask

    function automatic logic [31:0] exp_rd();
        if (cpu_adr[31:12] != 20'hFFFFF) return dram_rd;
        if (cpu_adr == 32'hFFFF_F070) return {8'h0, m_sw_hist[1]};
        if (cpu_adr == 32'hFFFF_F078) return {27'h0, m_btn_hist[1]};
        return 32'h0;
    endfunction

    task automatic check_all(input string tag);
        logic [31:0] exp_da;
        exp_da = (cpu_adr >> 2) & ((32'h1 << DRAM_AW) - 1);
        check({tag, ".cpu_rd"}, cpu_rd, exp_rd());
        check({tag, ".dram_we"}, {31'h0, dram_we}, {31'h0, cpu_we && cpu_adr[31:12] != 20'hFFFFF});
        check({tag, ".dram_addr"}, {18'h0, dram_addr}, exp_da);
        check({tag, ".dram_wdin"}, dram_wdin, cpu_wdin);
        check({tag, ".led"}, {8'h0, led}, {8'h0, m_led});
        check({tag, ".dig_en"}, {24'h0, dig_en}, {24'h0, m_dig});
        check({tag, ".seg"}, {24'h0, seg}, {24'h0, m_seg});
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we);
        cpu_adr = a;
        cpu_wdin = d;
        cpu_we = we;
        #1;
    endtask

    initial begin
        logic [31:0] a;
        rst_n = 1'b0;
        cpu_adr = 32'h0; cpu_wdin = 32'h0; cpu_we = 1'b0;
        dram_rd = 32'h0; sw = 24'h0; btn = 5'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        #1;
        check_all("reset");

        // LED store
        drive(32'hFFFF_F060, 32'h00A5_A5A5, 1'b1);
        check("led.dram_we", {31'h0, dram_we}, 32'h0);
        tick();
        check("led.value", {8'h0, led}, 32'h00A5_A5A5);
        drive(32'h0, 32'h0, 1'b0);
        repeat (5) tick();
        check_all("midscan");

        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        check("areset.led", {8'h0, led}, 32'h0);
        check("areset.dig_en", {24'h0, dig_en}, 32'hFE);
        check("areset.seg", {24'h0, seg}, 32'hC0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_all("post_reset");

        // Switch synchroniser latency
        drive(32'hFFFF_F070, 32'h0, 1'b0);
        sw = 24'h123456;
        #1;
        check("sw.edge0", cpu_rd, 32'h0);
        tick();
        check("sw.edge1", cpu_rd, 32'h0);
        tick();
        check("sw.edge2", cpu_rd, 32'h0012_3456);
        btn = 5'h15;
        drive(32'hFFFF_F078, 32'h0, 1'b0);
        tick(); tick();
        check("btn.edge2", cpu_rd, 32'h15);

        // Display scan pattern
        drive(32'hFFFF_F000, 32'h89AB_CDEF, 1'b1);
        tick();
        drive(32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            tick();
            check_all("scan");
        end

        // DRAM store and load
        drive(32'h0000_0104, 32'hDEAD_BEEF, 1'b1);
        check("dram.addr", {18'h0, dram_addr}, 32'h041);
        check("dram.we", {31'h0, dram_we}, 32'h1);
        check("dram.wdin", dram_wdin, 32'hDEAD_BEEF);
        tick();
        dram_rd = 32'hDEAD_BEEF;
        drive(32'h0000_0104, 32'h0, 1'b0);
        check("dram.load", cpu_rd, 32'hDEAD_BEEF);

        // Unmapped page address
        drive(32'hFFFF_F100, 32'h1234_5678, 1'b1);
        check("unmapped.dram_we", {31'h0, dram_we}, 32'h0);
        check("unmapped.rd", cpu_rd, 32'h0);
        tick();
        check_all("unmapped");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0: begin
                    a = $urandom;
                    if (a[31:12] == 20'hFFFFF) a[31] = 1'b0;
                end
                1: a = 32'hFFFF_F000;
                2: a = 32'hFFFF_F060;
                3: a = 32'hFFFF_F070;
                4: a = 32'hFFFF_F078;
                default: a = 32'hFFFF_F100 + 32'($urandom_range(0, 959)) * 4;
            endcase
            sw = 24'($urandom);
            btn = 5'($urandom);
            dram_rd = $urandom;
            drive(a, $urandom, 1'($urandom_range(0, 1)));
            check_all("rand");
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
